// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data memory for the ARM pipeline.
// Byte/half/word loads and stores on little-endian lanes, signed or unsigned
// sub-word loads, alignment/range fault detection, a valid/ready request port,
// a registered one-cycle response and a post-reset clear sequencer.
module data_mem_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 256,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              init_done
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-2:0] DEPTH_L  = (ADDR_W-1)'(DEPTH);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte-enable mask for a store of the given size at the given lane.
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate sub-word store data across all lanes so the mask picks the right one.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Select the addressed byte/half from a word and zero- or sign-extend it.
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lane,
                                                 input logic sgn, input logic [31:0] word);
        logic [7:0]  b_v;
        logic [15:0] h_v;
        case (lane)
            2'd0:    b_v = word[7:0];
            2'd1:    b_v = word[15:8];
            2'd2:    b_v = word[23:16];
            default: b_v = word[31:24];
        endcase
        h_v = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return sgn ? {{24{b_v[7]}}, b_v} : {24'h000000, b_v};
            SZ_HALF: return sgn ? {{16{h_v[15]}}, h_v} : {16'h0000, h_v};
            SZ_WORD: return word;
            default: return 32'h00000000;
        endcase
    endfunction

    logic [31:0]       mem_r [DEPTH];
    logic [0:0]        state_r;
    logic [IDX_W-1:0]  init_ptr_r;
    logic              req_ready_r;
    logic              init_done_r;
    logic              rsp_valid_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_fault_r;

    logic [ADDR_W-3:0] word_idx_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic [1:0]        lane_s;
    logic              fault_s;
    logic              accept_s;
    logic              wr_en_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       ld_data_s;

    // Request decode: index, lane, fault classification, write mask and load data.
    always_comb begin
        word_idx_s = req_addr[ADDR_W-1:2];
        mem_idx_s  = word_idx_s[IDX_W-1:0];
        lane_s     = req_addr[1:0];
        fault_s    = 1'b0;
        if (req_size == 2'b11) begin
            fault_s = 1'b1;
        end else if ((req_size == SZ_HALF) && req_addr[0]) begin
            fault_s = 1'b1;
        end else if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) begin
            fault_s = 1'b1;
        end else if ({1'b0, word_idx_s} >= DEPTH_L) begin
            fault_s = 1'b1;
        end else begin
            fault_s = 1'b0;
        end
        accept_s  = req_valid & req_ready_r;
        wr_en_s   = accept_s & req_we & ~fault_s;
        be_s      = lane_enable(req_size, lane_s);
        wdata_s   = store_lanes(req_size, req_wdata);
        rd_word_s = mem_r[mem_idx_s];
        ld_data_s = load_extract(req_size, lane_s, req_signed, rd_word_s);
    end

    // Storage array: zero-fill during INIT, byte-masked stores once ready.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_r == ST_INIT) begin
                mem_r[init_ptr_r] <= 32'h00000000;
            end else if (wr_en_s) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_s[i]) begin
                        mem_r[mem_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                    end
                end
            end
        end
    end

    // Clear sequencer and ready/done flags; READY is terminal until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= INIT_CLEAR ? ST_INIT : ST_READY;
            init_ptr_r  <= '0;
            req_ready_r <= 1'b0;
            init_done_r <= INIT_CLEAR ? 1'b0 : 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_ptr_r <= init_ptr_r + IDX_W'(1);
                    if (init_ptr_r == LAST_IDX) begin
                        state_r     <= ST_READY;
                        req_ready_r <= 1'b1;
                        init_done_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    req_ready_r <= 1'b1;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_ptr_r  <= '0;
                    req_ready_r <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle registered response; data/fault forced to 0 outside a valid cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h00000000;
            rsp_fault_r <= 1'b0;
        end else begin
            rsp_valid_r <= accept_s;
            rsp_fault_r <= accept_s & fault_s;
            rsp_rdata_r <= (accept_s && !req_we && !fault_s) ? ld_data_s : 32'h00000000;
        end
    end

    assign req_ready = req_ready_r;
    assign init_done = init_done_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_fault = rsp_fault_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vectors for data_mem_ctrl with DEPTH=8.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        init_done;

    int n_cmp;
    int n_err;

    data_mem_ctrl #(
        .ADDR_W    (32),
        .DEPTH     (8),
        .INIT_CLEAR(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; check the response right after the accepting edge.
    task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_f);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
        chk({tag, "_rdata"}, rsp_rdata, exp_d);
        chk({tag, "_fault"}, {31'h0, rsp_fault}, {31'h0, exp_f});
    endtask

    // One cycle with no request: response must be idle and zero.
    task automatic idle_chk(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_idle_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_idle_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_idle_fault"}, {31'h0, rsp_fault}, 32'h0);
    endtask

    // Release reset and walk the 8-cycle clear; a store held during INIT must be ignored.
    task automatic run_init(input string tag);
        @(negedge clk);
        rst_n      = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h00000000;
        req_wdata  = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_ready_low"}, {31'h0, req_ready}, 32'h0);
            chk({tag, "_done_low"}, {31'h0, init_done}, 32'h0);
            chk({tag, "_no_rsp"}, {31'h0, rsp_valid}, 32'h0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_ready_high"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "_done_high"}, {31'h0, init_done}, 32'h1);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_done", {31'h0, init_done}, 32'h0);
        chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_fault", {31'h0, rsp_fault}, 32'h0);

        // 1: init sequence, memory cleared, INIT-time store ignored
        run_init("init");
        do_req("init_ld0c", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h00000000, 1'b0);
        do_req("init_ld00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h00000000, 1'b0);
        idle_chk("init");

        // 2: store then load same word on consecutive accepts
        do_req("raw_st", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("raw_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        idle_chk("raw");

        // 3: byte store to lane 1, signed/unsigned byte and half loads
        do_req("b_st", 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345680, 32'h0, 1'b0);
        do_req("b_lds", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req("b_ldu", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h00000080, 1'b0);
        do_req("b_ldw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
        do_req("b_ld3", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        do_req("h_lds", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        do_req("h_ldu", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h000080EF, 1'b0);
        do_req("h_st", 1'b1, 2'b01, 1'b0, 32'h0E, 32'hCAFE1234, 32'h0, 1'b0);
        do_req("h_ldw", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h12340000, 1'b0);

        // 4: misalignment and illegal size
        do_req("mis_h", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        do_req("mis_wst", 1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 32'h0, 1'b1);
        do_req("mis_chk", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
        do_req("sz11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);

        // 5: range boundary
        do_req("rng_ld8", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        do_req("rng_st8", 1'b1, 2'b00, 1'b0, 32'h20, 32'h55, 32'h0, 1'b1);
        do_req("rng_st7", 1'b1, 2'b10, 1'b0, 32'h1C, 32'hA5A55A5A, 32'h0, 1'b0);
        do_req("rng_ld7", 1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 32'hA5A55A5A, 1'b0);
        do_req("rng_ld0", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h00000000, 1'b0);
        idle_chk("rng");

        // 6: reset while a response is pending, then re-clear
        do_req("mid_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_valid", {31'h0, rsp_valid}, 32'h0);
        chk("mid_rdata", rsp_rdata, 32'h0);
        chk("mid_ready", {31'h0, req_ready}, 32'h0);
        chk("mid_done", {31'h0, init_done}, 32'h0);
        run_init("reinit");
        do_req("re_ld10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h00000000, 1'b0);
        do_req("re_ld1c", 1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 32'h00000000, 1'b0);
        idle_chk("re");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
